chip_access_sequencer: RTL and testbench

- Sequences every access to the external memristor accelerator chip: program, memory read, register read and row-sweep inference.
- Accepts one command at a time from the system bus over a valid/ready handshake.
- Drives instructions, row/column address and the CBL/CBLEN/CSL/CWL strobes with timed phases.
- Samples the chip's 4 data lines and returns a single-cycle response pulse.

---
 rtl/chip_access_sequencer_if.sv | 38 +++
 rtl/chip_access_sequencer.sv | 158 +++++++++++++++
 tb/tb_chip_access_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip_access_sequencer_if.sv
// Bus bundle between the system requester, the access sequencer and the memristor chip pins.
// The slave side is the sequencer; the master side is the requester plus the chip model.
interface chip_access_sequencer_if #(
  parameter int AddrWidth = 5,
  parameter int NumBits   = 4,
  parameter int CntWidth  = 6
);
  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [1:0]                   req_op_i;
  logic [AddrWidth-1:0]         req_row_i;
  logic [AddrWidth-1:0]         req_col_i;
  logic [AddrWidth-1:0]         req_len_i;
  logic                         req_wdata_i;
  logic                         rsp_valid_o;
  logic [NumBits*CntWidth-1:0]  rsp_data_o;
  logic                         busy_o;
  logic [1:0]                   instructions_o;
  logic [AddrWidth-1:0]         addr_row_o;
  logic [AddrWidth-1:0]         addr_col_o;
  logic                         cbl_o;
  logic                         cblen_o;
  logic                         csl_o;
  logic                         cwl_o;
  logic [NumBits-1:0]           bit_out_i;

  modport master (
    output req_valid_i, req_op_i, req_row_i, req_col_i, req_len_i, req_wdata_i, bit_out_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o, instructions_o,
           addr_row_o, addr_col_o, cbl_o, cblen_o, csl_o, cwl_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_row_i, req_col_i, req_len_i, req_wdata_i, bit_out_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, busy_o, instructions_o,
           addr_row_o, addr_col_o, cbl_o, cblen_o, csl_o, cwl_o
  );
endinterface

// File: rtl/chip_access_sequencer.sv
// Sequences program / read / inference accesses to the memristor chip with timed
// setup, active and hold phases, and returns a one-cycle response pulse.
module chip_access_sequencer #(
  parameter int AddrWidth   = 5,
  parameter int NumBits     = 4,
  parameter int CntWidth    = 6,
  parameter int SetupCycles = 2,
  parameter int PulseCycles = 4,
  parameter int SenseCycles = 3,
  parameter int HoldCycles  = 1
) (
  input logic                     clk_sys_in,
  input logic                     rst_sys_in,
  chip_access_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, DONE} state_t;

  localparam logic [1:0] OP_PROG = 2'b11;
  localparam logic [1:0] OP_RREG = 2'b01;
  localparam logic [1:0] OP_INF  = 2'b00;
  localparam logic [1:0] INSTR_NONDESTRUCT = 2'b01;

  // Counter is loaded with length-1 and the phase ends when it reaches zero.
  localparam logic [7:0] SETUP_LEN = 8'(SetupCycles - 1);
  localparam logic [7:0] PULSE_LEN = 8'(PulseCycles - 1);
  localparam logic [7:0] SENSE_LEN = 8'(SenseCycles - 1);
  localparam logic [7:0] HOLD_LEN  = 8'(HoldCycles - 1);

  state_t                             state;
  logic [7:0]                         cnt;
  logic [1:0]                         op_q;
  logic [AddrWidth-1:0]               last_row;
  logic [AddrWidth-1:0]               last_row_nxt;
  logic [AddrWidth:0]                 row_sum;
  logic [NumBits-1:0]                 sample_p0;
  logic [NumBits-1:0][CntWidth-1:0]   acc;
  logic [NumBits*CntWidth-1:0]        rsp_data;
  logic [1:0]                         instr;
  logic [AddrWidth-1:0]               addr_row;
  logic [AddrWidth-1:0]               addr_col;
  logic                               rsp_valid, cbl, cblen, csl, cwl;

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a, input logic b);
    return (b && (a != {CntWidth{1'b1}})) ? a + CntWidth'(1) : a;
  endfunction

  // The sweep stops at the top row instead of wrapping.
  assign row_sum      = {1'b0, bus.req_row_i} + {1'b0, bus.req_len_i};
  assign last_row_nxt = row_sum[AddrWidth] ? {AddrWidth{1'b1}} : row_sum[AddrWidth-1:0];

  always_ff @(posedge clk_sys_in) begin
    if (rst_sys_in) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= INSTR_NONDESTRUCT;
      last_row  <= '0;
      sample_p0 <= '0;
      acc       <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      instr     <= INSTR_NONDESTRUCT;
      addr_row  <= '0;
      addr_col  <= '0;
      cbl       <= 1'b0;
      cblen     <= 1'b0;
      csl       <= 1'b0;
      cwl       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            state    <= SETUP;
            cnt      <= SETUP_LEN;
            op_q     <= bus.req_op_i;
            instr    <= bus.req_op_i;
            addr_row <= bus.req_row_i;
            addr_col <= bus.req_col_i;
            last_row <= last_row_nxt;
            cbl      <= (bus.req_op_i == OP_PROG) && bus.req_wdata_i;
            acc      <= '0;
          end
        end
        // setup -> active: raise the op-specific strobes
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= ACTIVE;
            cnt   <= (op_q == OP_PROG) ? PULSE_LEN : SENSE_LEN;
            csl   <= 1'b1;
            cwl   <= (op_q != OP_RREG);
            cblen <= (op_q == OP_PROG);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        // active -> hold: capture the chip data lines on the closing edge
        ACTIVE: begin
          if (cnt == 8'd0) begin
            state     <= HOLD;
            cnt       <= HOLD_LEN;
            csl       <= 1'b0;
            cwl       <= 1'b0;
            cblen     <= 1'b0;
            sample_p0 <= bus.bit_out_i;
            if (op_q == OP_INF) begin
              for (int k = 0; k < NumBits; k++) acc[k] <= sat_add(acc[k], bus.bit_out_i[k]);
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        // hold -> next row or done
        HOLD: begin
          if (cnt == 8'd0) begin
            if ((op_q == OP_INF) && (addr_row != last_row)) begin
              state    <= SETUP;
              cnt      <= SETUP_LEN;
              addr_row <= addr_row + AddrWidth'(1);
            end else begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              cbl       <= 1'b0;
              if (op_q == OP_INF) begin
                rsp_data <= acc;
              end else if (op_q == OP_PROG) begin
                rsp_data <= '0;
              end else begin
                rsp_data                <= '0;
                rsp_data[NumBits-1:0]   <= sample_p0;
              end
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          instr     <= INSTR_NONDESTRUCT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o    = (state == IDLE) && !rst_sys_in;
  assign bus.busy_o         = (state != IDLE);
  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.rsp_data_o     = rsp_data;
  assign bus.instructions_o = instr;
  assign bus.addr_row_o     = addr_row;
  assign bus.addr_col_o     = addr_col;
  assign bus.cbl_o          = cbl;
  assign bus.cblen_o        = cblen;
  assign bus.csl_o          = csl;
  assign bus.cwl_o          = cwl;

endmodule

// File: tb/tb_chip_access_sequencer.sv
// Self-checking bench for chip_access_sequencer: per-cycle phase/strobe checks in each
// scenario task, response data checked by a scoreboard monitor.
module tb_chip_access_sequencer;
  localparam int AW = 5;
  localparam int NB = 4;
  localparam int CW = 4;
  localparam int RW = NB * CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chip_access_sequencer_if #(.AddrWidth(AW), .NumBits(NB), .CntWidth(CW)) bus ();

  chip_access_sequencer #(.AddrWidth(AW), .NumBits(NB), .CntWidth(CW)) dut (
    .clk_sys_in (clk),
    .rst_sys_in (rst),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: rsp_valid=1 data=%h, required no response", bus.rsp_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rsp_data_o !== mon_exp) begin
          n_bad++;
          $display("FAIL rsp_data: got %h required %h", bus.rsp_data_o, mon_exp);
        end
      end
    end
  end

  // Expected {cbl,cblen,csl,cwl} at position p (1-based) inside one setup/active/hold row.
  function automatic logic [3:0] exp_strb(input logic [1:0] op, input logic wd, input int p);
    int  a;
    logic c;
    a = (op == 2'b11) ? 4 : 3;
    c = (op == 2'b11) && wd;
    if (p >= 3 && p <= 2 + a) return {c, op == 2'b11, 1'b1, op != 2'b01};
    else if (p <= 3 + a)      return {c, 3'b000};
    else                      return 4'b0000;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] row, input logic [AW-1:0] col,
                       input logic [AW-1:0] len, input logic wd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.req_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard == 50) begin
      n_bad++;
      $display("FAIL issue_timeout: req_ready=%b required 1", bus.req_ready_o);
    end
    bus.req_op_i    = op;
    bus.req_row_i   = row;
    bus.req_col_i   = col;
    bus.req_len_i   = len;
    bus.req_wdata_i = wd;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready_o, bus.busy_o, bus.rsp_valid_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready/busy/rsp_valid=%b required 100",
               {bus.req_ready_o, bus.busy_o, bus.rsp_valid_o});
    end
    n_cmp++;
    if (bus.instructions_o !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_instr: got %b required 01", bus.instructions_o);
    end
    n_cmp++;
    if ({bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b required 0000",
               {bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o});
    end
    n_cmp++;
    if ({bus.addr_row_o, bus.addr_col_o, bus.rsp_data_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: row=%0d col=%0d data=%h required all 0",
               bus.addr_row_o, bus.addr_col_o, bus.rsp_data_o);
    end
  endtask

  // read_mem (10) and read_reg (01): response at T+7 with the sampled nibble.
  task automatic test_read(input logic [1:0] op, input logic [AW-1:0] row,
                           input logic [AW-1:0] col, input logic [NB-1:0] bits);
    logic [3:0] es;
    bus.bit_out_i = bits;
    exp_q.push_back(RW'(bits));
    issue(op, row, col, 5'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        n_cmp++;
        if ({bus.instructions_o, bus.addr_row_o, bus.addr_col_o} !== {op, row, col}) begin
          n_bad++;
          $display("FAIL read_addr k=%0d: instr/row/col=%b/%0d/%0d required %b/%0d/%0d",
                   k, bus.instructions_o, bus.addr_row_o, bus.addr_col_o, op, row, col);
        end
      end
      es = exp_strb(op, 1'b0, k);
      n_cmp++;
      if ({bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o} !== es) begin
        n_bad++;
        $display("FAIL read_strobes k=%0d: got %b required %b", k,
                 {bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o}, es);
      end
      n_cmp++;
      if ({bus.rsp_valid_o, bus.req_ready_o} !== {k == 7, k == 8}) begin
        n_bad++;
        $display("FAIL read_timing k=%0d: rsp_valid/ready=%b%b required %b%b", k,
                 bus.rsp_valid_o, bus.req_ready_o, k == 7, k == 8);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL read_drain: %0d responses outstanding required 0", exp_q.size());
    end
  endtask

  // prog: cbl follows wdata through hold, pulse of 4 cycles, response at T+8 with zero data.
  task automatic test_prog(input logic [AW-1:0] row, input logic [AW-1:0] col, input logic wd);
    logic [3:0] es;
    bus.bit_out_i = 4'b1111;
    exp_q.push_back('0);
    issue(2'b11, row, col, 5'd0, wd);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        n_cmp++;
        if ({bus.instructions_o, bus.addr_row_o, bus.addr_col_o} !== {2'b11, row, col}) begin
          n_bad++;
          $display("FAIL prog_addr k=%0d: instr/row/col=%b/%0d/%0d required 11/%0d/%0d",
                   k, bus.instructions_o, bus.addr_row_o, bus.addr_col_o, row, col);
        end
      end
      es = exp_strb(2'b11, wd, k);
      n_cmp++;
      if ({bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o} !== es) begin
        n_bad++;
        $display("FAIL prog_strobes k=%0d: got %b required %b", k,
                 {bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o}, es);
      end
      n_cmp++;
      if ({bus.rsp_valid_o, bus.req_ready_o, bus.busy_o} !== {k == 8, k == 9, k != 9}) begin
        n_bad++;
        $display("FAIL prog_timing k=%0d: rsp_valid/ready/busy=%b%b%b required %b%b%b", k,
                 bus.rsp_valid_o, bus.req_ready_o, bus.busy_o, k == 8, k == 9, k != 9);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL prog_drain: %0d responses outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_inference(input logic [AW-1:0] row, input logic [AW-1:0] len,
                                input logic [NB-1:0] bits, input logic [RW-1:0] exp_data);
    int rows, lat, top, r;
    logic [3:0] es;
    top  = (int'(row) + int'(len) > 31) ? 31 : int'(row) + int'(len);
    rows = top - int'(row) + 1;
    lat  = rows * 6 + 1;
    bus.bit_out_i = bits;
    exp_q.push_back(exp_data);
    issue(2'b00, row, 5'd4, len, 1'b0);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k < lat) begin
        r  = int'(row) + (k - 1) / 6;
        es = exp_strb(2'b00, 1'b0, (k - 1) % 6 + 1);
        n_cmp++;
        if ({bus.addr_row_o, bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o} !== {AW'(r), es}) begin
          n_bad++;
          $display("FAIL inf_row_strobes k=%0d: row=%0d strobes=%b required row=%0d strobes=%b",
                   k, bus.addr_row_o, {bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o}, r, es);
        end
      end
      n_cmp++;
      if (bus.rsp_valid_o !== (k == lat)) begin
        n_bad++;
        $display("FAIL inf_timing k=%0d: rsp_valid=%b required %b", k, bus.rsp_valid_o, k == lat);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL inf_drain: %0d responses outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_prog();
    bus.bit_out_i = 4'b0011;
    issue(2'b11, 5'd12, 5'd3, 5'd0, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.cblen_o !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_in_pulse: cblen=%b required 1", bus.cblen_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o, bus.busy_o, bus.rsp_valid_o, bus.req_ready_o}
        !== 7'b0000000) begin
      n_bad++;
      $display("FAIL midrst_ctrl: strobes/busy/rsp_valid/ready=%b required 0000000",
               {bus.cbl_o, bus.cblen_o, bus.csl_o, bus.cwl_o, bus.busy_o, bus.rsp_valid_o,
                bus.req_ready_o});
    end
    n_cmp++;
    if ({bus.instructions_o, bus.addr_row_o, bus.addr_col_o} !== {2'b01, 10'd0}) begin
      n_bad++;
      $display("FAIL midrst_instr_addr: instr/row/col=%b/%0d/%0d required 01/0/0",
               bus.instructions_o, bus.addr_row_o, bus.addr_col_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.rsp_valid_o, bus.busy_o, bus.req_ready_o} !== 3'b001) begin
        n_bad++;
        $display("FAIL midrst_quiet k=%0d: rsp_valid/busy/ready=%b required 001", k,
                 {bus.rsp_valid_o, bus.busy_o, bus.req_ready_o});
      end
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'b00;
    bus.req_row_i   = '0;
    bus.req_col_i   = '0;
    bus.req_len_i   = '0;
    bus.req_wdata_i = 1'b0;
    bus.bit_out_i   = '0;
    test_reset();
    test_read(2'b10, 5'd5, 5'd9, 4'b1010);
    test_prog(5'd31, 5'd0, 1'b1);
    test_read(2'b01, 5'd17, 5'd2, 4'b0110);
    test_prog(5'd8, 5'd21, 1'b0);
    test_inference(5'd30, 5'd5, 4'b0001, 16'h0002);
    test_inference(5'd10, 5'd2, 4'b0110, 16'h0330);
    test_inference(5'd0, 5'd31, 4'b1111, 16'hFFFF);
    test_reset_mid_prog();
    test_read(2'b10, 5'd3, 5'd7, 4'b0101);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
